// File: rtl/dffsr_bank.sv
// rtl/dffsr_bank.sv - WIDTH-bit register bank with sync set/clear, mode-selected next state, change pulse
// Optional parity output compiled in with DFFSR_BANK_PARITY_EN.
module dffsr_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed
`ifdef DFFSR_BANK_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_TOG   = 3'b110;
  localparam logic [2:0] MODE_XLOAD = 3'b111;

  logic [WIDTH-1:0] q_next;

  // Shifts written with << / >> so WIDTH=1 degenerates cleanly:
  // shifts take the serial input, rotates reduce to hold.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (set) begin
      q_next = '1;
    end else begin
      case (mode)
        MODE_HOLD:  q_next = q;
        MODE_LOAD:  q_next = d;
        MODE_SHL:   q_next = (q << 1) | WIDTH'(sin_lsb);
        MODE_SHR:   q_next = (q >> 1) | (WIDTH'(sin_msb) << (WIDTH - 1));
        MODE_ROL:   q_next = (q << 1) | (q >> (WIDTH - 1));
        MODE_ROR:   q_next = (q >> 1) | (q << (WIDTH - 1));
        MODE_TOG:   q_next = ~q;
        MODE_XLOAD: q_next = q ^ d;
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VALUE;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= (q_next != q);
    end
  end

`ifdef DFFSR_BANK_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= ^RESET_VALUE;
    end else begin
      parity <= ^q_next;
    end
  end
`endif

  assign q_n = ~q;

endmodule

// File: tb/tb_dffsr_bank.sv
// tb/tb_dffsr_bank.sv - directed plus random checks of dffsr_bank against an arithmetic model
// Checks the parity output as well when DFFSR_BANK_PARITY_EN is defined.
module tb_dffsr_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin_lsb = 1'b0;
  logic       sin_msb = 1'b0;
  logic [7:0] q;
  logic [7:0] q_n;
  logic       changed;
`ifdef DFFSR_BANK_PARITY_EN
  logic       parity;
`endif

  int total = 0;
  int bad = 0;
  int model_q = 0;
  int model_changed = 0;

  dffsr_bank #(.WIDTH(8), .RESET_VALUE(RV)) dut (
    .clk(clk),
    .reset(reset),
    .set(set),
    .clr(clr),
    .mode(mode),
    .d(d),
    .sin_lsb(sin_lsb),
    .sin_msb(sin_msb),
    .q(q),
    .q_n(q_n),
    .changed(changed)
`ifdef DFFSR_BANK_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  // Next value computed with plain integer arithmetic on 0..255.
  function automatic int model_next(int cur, int s, int c, int m, int dv, int sl, int sm);
    if (c != 0) return 0;
    if (s != 0) return 255;
    case (m)
      1: return dv;
      2: return (cur * 2 + sl) % 256;
      3: return cur / 2 + sm * 128;
      4: return (cur * 2) % 256 + cur / 128;
      5: return cur / 2 + (cur % 2) * 128;
      6: return 255 - cur;
      7: return cur ^ dv;
      default: return cur;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [7:0] eq;
    eq = 8'(model_q);
    total++;
    assert (q === eq) else begin
      bad++;
      $error("FAIL %s q: got %h want %h", tag, q, eq);
    end
    total++;
    assert (q_n === ~eq) else begin
      bad++;
      $error("FAIL %s q_n: got %h want %h", tag, q_n, ~eq);
    end
    total++;
    assert (changed === 1'(model_changed)) else begin
      bad++;
      $error("FAIL %s changed: got %b want %0d", tag, changed, model_changed);
    end
`ifdef DFFSR_BANK_PARITY_EN
    total++;
    assert (parity === 1'($countones(eq) % 2)) else begin
      bad++;
      $error("FAIL %s parity: got %b want %0d", tag, parity, $countones(eq) % 2);
    end
`endif
  endtask

  task automatic expect_q(input string tag, input logic [7:0] want, input logic want_chg);
    total++;
    assert (q === want && changed === want_chg) else begin
      bad++;
      $error("FAIL %s literal: got q=%h changed=%b want q=%h changed=%b", tag, q, changed, want, want_chg);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic c, input logic [2:0] m,
                      input logic [7:0] dv, input logic sl, input logic sm, input string tag);
    int nxt;
    @(negedge clk);
    reset = r; set = s; clr = c; mode = m; d = dv; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    if (r) begin
      model_q = int'(RV);
      model_changed = 0;
    end else begin
      nxt = model_next(model_q, int'(s), int'(c), int'(m), int'(dv), int'(sl), int'(sm));
      model_changed = (nxt != model_q) ? 1 : 0;
      model_q = nxt;
    end
    #1;
    check(tag);
  endtask

  initial begin
    // 1. reset and toggle
    step(1, 0, 0, 3'b000, 8'h00, 0, 0, "reset0");
    step(1, 0, 0, 3'b000, 8'h00, 0, 0, "reset1");
    expect_q("reset_val", 8'hA5, 1'b0);
    total++;
    assert (q_n === 8'h5A) else begin
      bad++;
      $error("FAIL reset_qn: got %h want 5a", q_n);
    end
    step(0, 0, 0, 3'b110, 8'h00, 0, 0, "toggle");
    expect_q("toggle_val", 8'h5A, 1'b1);

    // 2. set/clear priority
    step(0, 1, 0, 3'b000, 8'h00, 0, 0, "set");
    expect_q("set_val", 8'hFF, 1'b1);
    step(0, 1, 1, 3'b000, 8'h00, 0, 0, "set_clr");
    expect_q("set_clr_val", 8'h00, 1'b1);
    step(1, 1, 1, 3'b000, 8'h00, 0, 0, "set_clr_rst");
    expect_q("set_clr_rst_val", RV, 1'b0);
    step(0, 1, 0, 3'b001, 8'h3C, 0, 0, "set_over_load");
    expect_q("set_over_load_val", 8'hFF, 1'b1);

    // 3. shift
    step(0, 0, 0, 3'b001, 8'h81, 0, 0, "load81");
    step(0, 0, 0, 3'b010, 8'h00, 1, 0, "shl");
    expect_q("shl_val", 8'h03, 1'b1);
    step(0, 0, 0, 3'b011, 8'h00, 0, 0, "shr");
    expect_q("shr_val", 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3'b000, 8'h00, 0, 0, "hold");
      expect_q("hold_val", 8'h01, 1'b0);
    end

    // 4. rotate
    step(0, 0, 0, 3'b001, 8'h81, 0, 0, "load81b");
    step(0, 0, 0, 3'b100, 8'h00, 0, 0, "rol");
    expect_q("rol_val", 8'h03, 1'b1);
    step(0, 0, 0, 3'b101, 8'h00, 0, 0, "ror1");
    step(0, 0, 0, 3'b101, 8'h00, 0, 0, "ror2");
    expect_q("ror2_val", 8'hC0, 1'b1);
    step(0, 0, 0, 3'b001, 8'h01, 0, 0, "load01");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 3'b100, 8'h00, 0, 0, "rol8");
    end
    expect_q("rol8_val", 8'h01, 1'b1);

    // 5. xor-load and no-change
    step(0, 0, 0, 3'b001, 8'hF0, 0, 0, "loadF0");
    step(0, 0, 0, 3'b111, 8'h0F, 0, 0, "xor0F");
    expect_q("xor0F_val", 8'hFF, 1'b1);
    step(0, 0, 0, 3'b111, 8'h00, 0, 0, "xor00");
    expect_q("xor00_val", 8'hFF, 1'b0);
    step(0, 0, 0, 3'b001, 8'hFF, 0, 0, "loadFF");
    expect_q("loadFF_val", 8'hFF, 1'b0);

    // 6. reset mid-shift
    step(0, 0, 0, 3'b001, 8'hAA, 0, 0, "loadAA");
    step(0, 0, 0, 3'b010, 8'h00, 0, 0, "shAA1");
    step(0, 0, 0, 3'b010, 8'h00, 0, 0, "shAA2");
    step(1, 0, 0, 3'b010, 8'h00, 0, 0, "shAA_rst");
    expect_q("mid_rst_val", RV, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
